// File: rtl/vram_arbiter.sv
// vram_arbiter: two-master arbiter for the framebuffer VRAM port (round-robin or fixed priority).
// Define VRAM_ARB_STATS_EN to enable saturating per-master completed-transaction counters.
module vram_arbiter #(
    parameter int ADDR_W     = 24,
    parameter int DATA_W     = 16,
    parameter int FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset_i,
    input  logic              m0_sel_i,
    input  logic              m0_wr_i,
    input  logic [3:0]        m0_mask_i,
    input  logic [ADDR_W-1:0] m0_address_i,
    input  logic [DATA_W-1:0] m0_data_i,
    output logic              m0_ack_o,
    output logic [DATA_W-1:0] m0_data_o,
    input  logic              m1_sel_i,
    input  logic              m1_wr_i,
    input  logic [3:0]        m1_mask_i,
    input  logic [ADDR_W-1:0] m1_address_i,
    input  logic [DATA_W-1:0] m1_data_i,
    output logic              m1_ack_o,
    output logic [DATA_W-1:0] m1_data_o,
    output logic              vram_sel_o,
    output logic              vram_wr_o,
    output logic [3:0]        vram_mask_o,
    output logic [ADDR_W-1:0] vram_address_o,
    output logic [DATA_W-1:0] vram_data_o,
    input  logic              vram_ack_i,
    input  logic [DATA_W-1:0] vram_data_i,
    output logic [31:0]       stats_m0_o,
    output logic [31:0]       stats_m1_o
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t r_state, w_next;
    logic   r_grant, r_last, w_grant_next, w_ack;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_grant <= 1'b0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_next;
            r_grant <= w_grant_next;
            if (w_ack)
                r_last <= r_grant;
        end
    end

    // Ties go to the master that was not served last, unless fixed priority favours m0.
    always_comb begin
        w_next       = r_state;
        w_grant_next = r_grant;
        w_ack        = 1'b0;
        if (r_state == IDLE) begin
            if (m0_sel_i || m1_sel_i) begin
                w_next       = BUSY;
                w_grant_next = (m0_sel_i && m1_sel_i) ? ((FIXED_PRIO != 0) ? 1'b0 : ~r_last) : m1_sel_i;
            end
        end else if (vram_ack_i) begin
            w_ack  = 1'b1;
            w_next = IDLE;
        end
    end

    assign vram_sel_o     = (r_state == BUSY);
    assign vram_wr_o      = r_grant ? m1_wr_i      : m0_wr_i;
    assign vram_mask_o    = r_grant ? m1_mask_i    : m0_mask_i;
    assign vram_address_o = r_grant ? m1_address_i : m0_address_i;
    assign vram_data_o    = r_grant ? m1_data_i    : m0_data_i;
    assign m0_ack_o       = w_ack && !r_grant;
    assign m1_ack_o       = w_ack && r_grant;
    assign m0_data_o      = vram_data_i;
    assign m1_data_o      = vram_data_i;

`ifdef VRAM_ARB_STATS_EN
    logic [31:0] r_stats_m0, r_stats_m1;

    always_ff @(posedge clk) begin
        if (reset_i) begin
            r_stats_m0 <= 32'd0;
            r_stats_m1 <= 32'd0;
        end else begin
            if (m0_ack_o && r_stats_m0 != 32'hFFFF_FFFF)
                r_stats_m0 <= r_stats_m0 + 32'd1;
            if (m1_ack_o && r_stats_m1 != 32'hFFFF_FFFF)
                r_stats_m1 <= r_stats_m1 + 32'd1;
        end
    end

    assign stats_m0_o = r_stats_m0;
    assign stats_m1_o = r_stats_m1;
`else
    assign stats_m0_o = 32'd0;
    assign stats_m1_o = 32'd0;
`endif
endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: directed scoreboard bench for vram_arbiter (round-robin DUT plus a fixed-priority copy).
module tb_vram_arbiter;
    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef VRAM_ARB_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        reset_i = 1'b1;
    logic        m0_sel_i = 0, m0_wr_i = 0, m1_sel_i = 0, m1_wr_i = 0;
    logic [3:0]  m0_mask_i = 0, m1_mask_i = 0;
    logic [23:0] m0_address_i = 0, m1_address_i = 0;
    logic [15:0] m0_data_i = 0, m1_data_i = 0;
    logic        m0_ack_o, m1_ack_o;
    logic [15:0] m0_data_o, m1_data_o;
    logic        vram_sel_o, vram_wr_o;
    logic [3:0]  vram_mask_o;
    logic [23:0] vram_address_o;
    logic [15:0] vram_data_o;
    logic        vram_ack_i = 0;
    logic [15:0] vram_data_i = 0;
    logic [31:0] stats_m0_o, stats_m1_o;

    logic        p_m0_sel = 0, p_m1_sel = 0, p_ack = 0;
    logic        p_m0_ack, p_m1_ack, p_sel, p_wr;
    logic [15:0] p_m0_data, p_m1_data, p_vdata;
    logic [3:0]  p_mask;
    logic [23:0] p_addr;
    logic [31:0] p_s0, p_s1;

    vram_arbiter dut (
        .clk(clk), .reset_i(reset_i),
        .m0_sel_i(m0_sel_i), .m0_wr_i(m0_wr_i), .m0_mask_i(m0_mask_i), .m0_address_i(m0_address_i),
        .m0_data_i(m0_data_i), .m0_ack_o(m0_ack_o), .m0_data_o(m0_data_o),
        .m1_sel_i(m1_sel_i), .m1_wr_i(m1_wr_i), .m1_mask_i(m1_mask_i), .m1_address_i(m1_address_i),
        .m1_data_i(m1_data_i), .m1_ack_o(m1_ack_o), .m1_data_o(m1_data_o),
        .vram_sel_o(vram_sel_o), .vram_wr_o(vram_wr_o), .vram_mask_o(vram_mask_o),
        .vram_address_o(vram_address_o), .vram_data_o(vram_data_o),
        .vram_ack_i(vram_ack_i), .vram_data_i(vram_data_i),
        .stats_m0_o(stats_m0_o), .stats_m1_o(stats_m1_o)
    );

    vram_arbiter #(.FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset_i(reset_i),
        .m0_sel_i(p_m0_sel), .m0_wr_i(1'b0), .m0_mask_i(4'h0), .m0_address_i(24'h0),
        .m0_data_i(16'h0), .m0_ack_o(p_m0_ack), .m0_data_o(p_m0_data),
        .m1_sel_i(p_m1_sel), .m1_wr_i(1'b0), .m1_mask_i(4'h0), .m1_address_i(24'h0),
        .m1_data_i(16'h0), .m1_ack_o(p_m1_ack), .m1_data_o(p_m1_data),
        .vram_sel_o(p_sel), .vram_wr_o(p_wr), .vram_mask_o(p_mask),
        .vram_address_o(p_addr), .vram_data_o(p_vdata),
        .vram_ack_i(p_ack), .vram_data_i(16'h0),
        .stats_m0_o(p_s0), .stats_m1_o(p_s1)
    );

    typedef struct packed {
        logic        who;
        logic [15:0] data;
    } exp_t;

    exp_t q[$];
    int   vectors = 0, errors = 0, e0 = 0, e1 = 0;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", n, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every routed ack must match the next expected completion.
    always @(negedge clk) begin
        if (m0_ack_o || m1_ack_o) begin
            if (q.size() == 0) begin
                chk("unexpected_ack", {30'd0, m1_ack_o, m0_ack_o}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("ack_onehot", {31'd0, m0_ack_o & m1_ack_o}, 32'd0);
                chk("ack_master", {31'd0, m1_ack_o}, {31'd0, e.who});
                chk("ack_data", m1_ack_o ? m1_data_o : m0_data_o, e.data);
            end
        end
    end

    task automatic wait_sel(output int n);
        n = 0;
        while (!vram_sel_o && n < 20) begin
            tick();
            n++;
        end
        chk("sel_wait", vram_sel_o, 1);
    endtask

    task automatic do_reset();
        reset_i = 1'b1;
        tick();
        tick();
        reset_i = 1'b0;
        e0 = 0;
        e1 = 0;
        chk("rst_sel", vram_sel_o, 0);
        chk("rst_acks", {m1_ack_o, m0_ack_o}, 0);
        chk("rst_stats0", stats_m0_o, 0);
        chk("rst_stats1", stats_m1_o, 0);
    endtask

    task automatic xact(input logic m, input logic wr, input logic [23:0] a, input logic [15:0] d,
                        input int dly, input logic [15:0] rd);
        int n;
        if (m) begin
            m1_sel_i = 1; m1_wr_i = wr; m1_address_i = a; m1_data_i = d; m1_mask_i = 4'hA;
        end else begin
            m0_sel_i = 1; m0_wr_i = wr; m0_address_i = a; m0_data_i = d; m0_mask_i = 4'h5;
        end
        chk("sel_idle", vram_sel_o, 0);
        wait_sel(n);
        chk("sel_latency", n, 1);
        chk("mux_addr", vram_address_o, a);
        chk("mux_data", vram_data_o, d);
        chk("mux_wr", vram_wr_o, wr);
        chk("mux_mask", vram_mask_o, m ? 4'hA : 4'h5);
        repeat (dly) tick();
        vram_ack_i = 1;
        vram_data_i = rd;
        q.push_back(exp_t'{who: m, data: rd});
        if (m) e1++; else e0++;
        tick();
        vram_ack_i = 0;
        m0_sel_i = 0;
        m1_sel_i = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n, c0, c1;
        do_reset();
        // single write then single read
        xact(1'b0, 1'b1, 24'h000010, 16'hABCD, 3, 16'h0000);
        chk("idle_after_ack", vram_sel_o, 0);
        xact(1'b1, 1'b0, 24'h000020, 16'h0000, 0, 16'h1234);
        // spurious ack in IDLE
        vram_ack_i = 1; vram_data_i = 16'hDEAD;
        @(negedge clk);
        chk("spurious_ack", {m1_ack_o, m0_ack_o}, 0);
        tick();
        vram_ack_i = 0;
        chk("spurious_idle", vram_sel_o, 0);
        // reset while busy
        m0_sel_i = 1;
        tick();
        chk("busy_sel", vram_sel_o, 1);
        reset_i = 1; m0_sel_i = 0;
        tick();
        chk("rst_busy_sel", vram_sel_o, 0);
        chk("rst_busy_acks", {m1_ack_o, m0_ack_o}, 0);
        reset_i = 0; e0 = 0; e1 = 0;
        tick();
        chk("rst_busy_idle", vram_sel_o, 0);
        // m0 drops sel while busy
        m0_sel_i = 1; m0_address_i = 24'h000333;
        wait_sel(n);
        m0_sel_i = 0;
        tick();
        chk("drop_held", vram_sel_o, 1);
        tick();
        vram_ack_i = 1; vram_data_i = 16'h0BAD;
        q.push_back(exp_t'{who: 1'b0, data: 16'h0BAD});
        e0++;
        tick();
        vram_ack_i = 0;
        chk("drop_idle", vram_sel_o, 0);
        // round-robin contention from reset: m0,m1,m0,m1,m0,m1
        do_reset();
        m0_address_i = 24'h000100; m0_data_i = 16'hAAAA;
        m1_address_i = 24'h000200; m1_data_i = 16'h5555;
        m0_sel_i = 1; m1_sel_i = 1;
        for (int i = 0; i < 6; i++) begin
            wait_sel(n);
            chk("rr_addr", vram_address_o, (i % 2 == 1) ? 32'h200 : 32'h100);
            vram_ack_i = 1; vram_data_i = 16'h7000 + 16'(i);
            q.push_back(exp_t'{who: (i % 2 == 1), data: 16'h7000 + 16'(i)});
            if (i % 2 == 1) e1++; else e0++;
            tick();
            vram_ack_i = 0;
        end
        m0_sel_i = 0; m1_sel_i = 0;
        tick();
        // fixed priority: m0 wins every tie
        c0 = 0; c1 = 0;
        p_m0_sel = 1; p_m1_sel = 1;
        for (int i = 0; i < 6; i++) begin
            n = 0;
            while (!p_sel && n < 20) begin
                tick();
                n++;
            end
            chk("fp_sel_wait", p_sel, 1);
            p_ack = 1;
            @(negedge clk);
            c0 += int'(p_m0_ack);
            c1 += int'(p_m1_ack);
            tick();
            p_ack = 0;
        end
        p_m0_sel = 0; p_m1_sel = 0;
        chk("fp_m0_grants", c0, 6);
        chk("fp_m1_grants", c1, 0);
        // counters: 5 m0 + 3 m1
        do_reset();
        for (int i = 0; i < 5; i++) xact(1'b0, 1'b1, 24'h001000 + 24'(i), 16'h1100 + 16'(i), i % 3, 16'h0);
        for (int i = 0; i < 3; i++) xact(1'b1, 1'b0, 24'h002000 + 24'(i), 16'h0, i, 16'h2200 + 16'(i));
        tick();
        chk("stats_m0", stats_m0_o, STATS ? 32'd5 : 32'd0);
        chk("stats_m1", stats_m1_o, STATS ? 32'd3 : 32'd0);
`ifdef VRAM_ARB_STATS_EN
        force dut.r_stats_m0 = 32'hFFFF_FFFE;
        #1;
        release dut.r_stats_m0;
        xact(1'b0, 1'b1, 24'h003000, 16'h3333, 1, 16'h0);
        tick();
        chk("stats_near_max", stats_m0_o, 32'hFFFF_FFFF);
        xact(1'b0, 1'b1, 24'h003001, 16'h3334, 1, 16'h0);
        tick();
        chk("stats_saturate", stats_m0_o, 32'hFFFF_FFFF);
        chk("stats_m1_keep", stats_m1_o, 32'd3);
`endif
        tick();
        chk("queue_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
